// File: rtl/fpcmp_pkg.sv
// Shared definitions for the floating-point compare sequencer.
// Predicate codes, flag bit positions and the sequencer state type.
package fpcmp_pkg;

    localparam logic [2:0] PRED_EQ  = 3'd0;
    localparam logic [2:0] PRED_NE  = 3'd1;
    localparam logic [2:0] PRED_LE  = 3'd2;
    localparam logic [2:0] PRED_LT  = 3'd3;
    localparam logic [2:0] PRED_ULE = 3'd4;
    localparam logic [2:0] PRED_ULT = 3'd5;

    localparam int FLAG_V = 4;
    localparam int FLAG_I = 3;
    localparam int FLAG_O = 2;
    localparam int FLAG_U = 1;
    localparam int FLAG_X = 0;

    localparam logic [4:0] FLAGS_INVALID = 5'(1) << FLAG_V;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } seq_state_e;

endpackage

// File: rtl/fpcmp_seq_wdog.sv
// Stall watchdog for the compare sequencer (built with FPCMP_SEQ_WDOG_EN).
// Counts stalled RUN cycles; expire fires on the TMO_CYCLES-th one.
module fpcmp_seq_wdog
    import fpcmp_pkg::*;
#(
    parameter int TMO_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic tick,
    output logic expire
);

    localparam logic [15:0] LIMIT = 16'(TMO_CYCLES - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Clear when a request enters RUN, count each stalled RUN cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    assign expire = tick && (cnt_q == LIMIT);

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fpcmp_seq.sv
// Command-side sequencer for the floating-point comparator.
// Optional stall watchdog and tmo port: define FPCMP_SEQ_WDOG_EN.
module fpcmp_seq
    import fpcmp_pkg::*;
#(
    parameter int TMO_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_pred,
    input  logic [31:0] req_x,
    input  logic [31:0] req_y,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_z,
    output logic [4:0]  rsp_flags,
    output logic        run,
    input  logic        stall,
    output logic [2:0]  pred,
    output logic [31:0] x,
    output logic [31:0] y,
    input  logic        z,
    input  logic [4:0]  flags,
    output logic [4:0]  sticky,
    input  logic        sticky_clr
`ifdef FPCMP_SEQ_WDOG_EN
    ,
    output logic        tmo
`endif
);

    if (TMO_CYCLES < 1 || TMO_CYCLES > 65535) begin : g_tmo_range
        $error("fpcmp_seq: TMO_CYCLES out of range 1..65535");
    end

    seq_state_e  state_q, state_d;
    logic [2:0]  pred_q, pred_d;
    logic [31:0] x_q, x_d;
    logic [31:0] y_q, y_d;
    logic        rsp_z_q, rsp_z_d;
    logic [4:0]  rsp_flags_q, rsp_flags_d;
    logic [4:0]  sticky_q, sticky_d;
    logic        run_q, run_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        accept;
    logic        capture;
    logic        abort;

    assign accept  = (state_q == ST_IDLE) && req_valid;
    assign capture = (state_q == ST_RUN) && !stall;

`ifdef FPCMP_SEQ_WDOG_EN
    logic tmo_q, tmo_d;
    logic expire;

    fpcmp_seq_wdog #(
        .TMO_CYCLES(TMO_CYCLES)
    ) u_wdog (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .tick  ((state_q == ST_RUN) && stall),
        .expire(expire)
    );

    assign abort = expire;

    // Abort indication survives until a sticky clear; a new abort wins.
    always_comb begin
        tmo_d = sticky_clr ? 1'b0 : tmo_q;
        if (abort) begin
            tmo_d = 1'b1;
        end
    end

    // Abort indicator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign tmo = tmo_q;
`else
    assign abort = 1'b0;
`endif

    // Next-state, operand and response capture logic.
    always_comb begin
        state_d     = state_q;
        pred_d      = pred_q;
        x_d         = x_q;
        y_d         = y_q;
        rsp_z_d     = rsp_z_q;
        rsp_flags_d = rsp_flags_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    pred_d  = req_pred;
                    x_d     = req_x;
                    y_d     = req_y;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    rsp_z_d     = z;
                    rsp_flags_d = flags;
                    state_d     = ST_RESP;
                end else if (abort) begin
                    rsp_z_d     = 1'b0;
                    rsp_flags_d = FLAGS_INVALID;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        run_d       = (state_d == ST_RUN);
        rsp_valid_d = (state_d == ST_RESP);
    end

    // Flags captured this cycle are ORed in after any clear.
    always_comb begin
        sticky_d = sticky_clr ? 5'b0 : sticky_q;
        if (capture) begin
            sticky_d = sticky_d | flags;
        end
        if (abort) begin
            sticky_d = sticky_d | FLAGS_INVALID;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pred_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            rsp_z_q     <= 1'b0;
            rsp_flags_q <= '0;
            sticky_q    <= '0;
            run_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pred_q      <= pred_d;
            x_q         <= x_d;
            y_q         <= y_d;
            rsp_z_q     <= rsp_z_d;
            rsp_flags_q <= rsp_flags_d;
            sticky_q    <= sticky_d;
            run_q       <= run_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_flags = rsp_flags_q;
    assign run       = run_q;
    assign pred      = pred_q;
    assign x         = x_q;
    assign y         = y_q;
    assign sticky    = sticky_q;

endmodule
